// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: funct codes, ALUOp/forwarding selects,
// internal operation and FSM enums, plus the funct decoder.
package ex_pkg;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_MUL = 6'h18;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_MUL, OP_ZERO
    } alu_op_e;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    // ALUOp 11 behaves as add; mul degrades to a zero result when the multiplier is absent.
    function automatic alu_op_e decode_op(input logic [1:0] alu_op, input logic [5:0] funct,
                                          input logic mul_en);
        alu_op_e op;
        op = OP_ADD;
        if (alu_op == ALUOP_SUB) op = OP_SUB;
        else if (alu_op == ALUOP_RTYPE) begin
            case (funct)
                FUNCT_ADD: op = OP_ADD;
                FUNCT_SUB: op = OP_SUB;
                FUNCT_AND: op = OP_AND;
                FUNCT_OR:  op = OP_OR;
                FUNCT_NOR: op = OP_NOR;
                FUNCT_SLT: op = OP_SLT;
                FUNCT_MUL: op = mul_en ? OP_MUL : OP_ZERO;
                default:   op = OP_ZERO;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/ex_stage_pipe_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, XLEN cycles per product.
// done/product are combinational on the final iteration so the caller can register them.
module ex_mul_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);
    localparam int CW = $clog2(XLEN);

    logic            busy;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] mcand, mplier, acc, acc_n;

    assign acc_n   = mplier[0] ? acc + mcand : acc;
    assign done    = busy && (cnt == CW'(XLEN - 1));
    assign product = acc_n;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            busy   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (busy) begin
            acc    <= acc_n;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= done ? '0 : cnt + 1'b1;
            busy   <= ~done;
        end
    end
endmodule

// File: rtl/ex_stage_pipe.sv
// Registered EX stage: forwarding, ALU, branch target, and a stalling multi-cycle mul.
// Outputs form the EX/MEM bundle; out_valid pulses once per accepted instruction.
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [5:0]      function_code,
    input  logic [1:0]      ALUOp,
    input  logic            ALUSrc,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [4:0]      rd,
    input  logic [1:0]      fwd_a_sel,
    input  logic [1:0]      fwd_b_sel,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic [XLEN-1:0] wb_fwd_data,
    input  logic            flush,
    output logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] ALU_result,
    output logic            Zero,
    output logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] branch_target,
    output logic [4:0]      out_rd
);
    state_e          state, state_n;
    alu_op_e         op;
    logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res, bt;
    logic [XLEN-1:0] pend_store, pend_bt, mul_prod;
    logic [4:0]      pend_rd;
    logic            accept, start_mul, mul_done;

    always_comb begin
        case (fwd_a_sel)
            FWD_MEM: op_a = mem_fwd_data;
            FWD_WB:  op_a = wb_fwd_data;
            default: op_a = data1;
        endcase
        case (fwd_b_sel)
            FWD_MEM: fwd_b = mem_fwd_data;
            FWD_WB:  fwd_b = wb_fwd_data;
            default: fwd_b = data2;
        endcase
    end

    assign op_b = ALUSrc ? imm : fwd_b;
    assign bt   = pc_plus4 + (imm << 2);
    assign op   = decode_op(ALUOp, function_code, MUL_EN);

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD: alu_res = op_a + op_b;
            OP_SUB: alu_res = op_a - op_b;
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_NOR: alu_res = ~(op_a | op_b);
            OP_SLT: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            default: alu_res = '0;
        endcase
    end

    assign stall     = (state == S_MUL);
    assign accept    = in_valid && (state == S_IDLE) && !flush;
    assign start_mul = accept && (op == OP_MUL);

    generate
        if (MUL_EN) begin : g_mul
            ex_mul_iter #(.XLEN(XLEN)) u_mul (
                .clk(clk), .rst(rst), .start(start_mul), .abort(flush),
                .a(op_a), .b(op_b), .done(mul_done), .product(mul_prod)
            );
        end else begin : g_nomul
            assign mul_done = 1'b0;
            assign mul_prod = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (start_mul) state_n = S_MUL;
            S_MUL:  if (flush || mul_done) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            ALU_result    <= '0;
            Zero          <= 1'b0;
            store_data    <= '0;
            branch_target <= '0;
            out_rd        <= '0;
            pend_store    <= '0;
            pend_bt       <= '0;
            pend_rd       <= '0;
        end else begin
            out_valid <= 1'b0;
            if (state == S_MUL) begin
                // flush on the final iteration still suppresses the result
                if (mul_done && !flush) begin
                    out_valid     <= 1'b1;
                    ALU_result    <= mul_prod;
                    Zero          <= (mul_prod == '0);
                    store_data    <= pend_store;
                    branch_target <= pend_bt;
                    out_rd        <= pend_rd;
                end
            end else if (start_mul) begin
                pend_store <= fwd_b;
                pend_bt    <= bt;
                pend_rd    <= rd;
            end else if (accept) begin
                out_valid     <= 1'b1;
                ALU_result    <= alu_res;
                Zero          <= (alu_res == '0);
                store_data    <= fwd_b;
                branch_target <= bt;
                out_rd        <= rd;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboarded bench for ex_stage_pipe (XLEN=32): ALU, branch, forwarding, mul stall,
// flush/reset abort, back-to-back, plus a MUL_EN=0 instance.
module tb_ex_stage_pipe;
    import ex_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic [31:0] st;
        logic [31:0] bt;
        logic [4:0]  rd;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_valid0 = 1'b0, ALUSrc = 1'b0, flush = 1'b0;
    logic [5:0]  function_code = '0;
    logic [1:0]  ALUOp = '0, fwd_a_sel = '0, fwd_b_sel = '0;
    logic [31:0] data1 = '0, data2 = '0, imm = '0, pc_plus4 = '0, mem_fwd_data = '0, wb_fwd_data = '0;
    logic [4:0]  rd = '0;

    logic        stall, out_valid, Zero, stall0, out_valid0, Zero0;
    logic [31:0] ALU_result, store_data, branch_target, ALU_result0, store_data0, branch_target0;
    logic [4:0]  out_rd, out_rd0;

    int   n_cmp = 0, n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    ex_stage_pipe #(.XLEN(32), .MUL_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .function_code(function_code), .ALUOp(ALUOp),
        .ALUSrc(ALUSrc), .data1(data1), .data2(data2), .imm(imm), .pc_plus4(pc_plus4), .rd(rd),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_data(wb_fwd_data), .flush(flush), .stall(stall), .out_valid(out_valid),
        .ALU_result(ALU_result), .Zero(Zero), .store_data(store_data),
        .branch_target(branch_target), .out_rd(out_rd)
    );

    ex_stage_pipe #(.XLEN(32), .MUL_EN(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .function_code(function_code), .ALUOp(ALUOp),
        .ALUSrc(ALUSrc), .data1(data1), .data2(data2), .imm(imm), .pc_plus4(pc_plus4), .rd(rd),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_data(wb_fwd_data), .flush(flush), .stall(stall0), .out_valid(out_valid0),
        .ALU_result(ALU_result0), .Zero(Zero0), .store_data(store_data0),
        .branch_target(branch_target0), .out_rd(out_rd0)
    );

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v,
                                         input logic [31:0] mf, input logic [31:0] wf);
        if (sel == 2'b01) return mf;
        if (sel == 2'b10) return wf;
        return reg_v;
    endfunction

    // Drive one ID/EX bundle; optionally record the reference result in the scoreboard.
    task automatic set_op(input logic [1:0] aop, input logic [5:0] fn, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] im, input logic [31:0] pc,
                          input logic [4:0] r, input logic src, input logic [1:0] fa,
                          input logic [1:0] fb, input logic [31:0] mf, input logic [31:0] wf,
                          input bit push);
        logic [31:0] a, bb, b, res;
        exp_t e;
        ALUOp = aop; function_code = fn; data1 = d1; data2 = d2; imm = im; pc_plus4 = pc;
        rd = r; ALUSrc = src; fwd_a_sel = fa; fwd_b_sel = fb; mem_fwd_data = mf;
        wb_fwd_data = wf; in_valid = 1'b1;
        a  = pick(fa, d1, mf, wf);
        bb = pick(fb, d2, mf, wf);
        b  = src ? im : bb;
        if (aop == 2'b01) res = a - b;
        else if (aop != 2'b10) res = a + b;
        else case (fn)
            6'h20: res = a + b;
            6'h22: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h27: res = ~(a | b);
            6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h18: res = a * b;
            default: res = 32'd0;
        endcase
        e.res = res; e.z = (res == 32'd0); e.st = bb; e.bt = pc + (im << 2); e.rd = r;
        if (push) sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: out_valid pulse with result %h, expected none", ALU_result);
                end else begin
                    e = sb.pop_front();
                    if ({ALU_result, Zero, store_data, branch_target, out_rd} !== {e.res, e.z, e.st, e.bt, e.rd}) begin
                        n_err++;
                        $display("FAIL sb_bundle: got res=%h z=%b st=%h bt=%h rd=%0d, want res=%h z=%b st=%h bt=%h rd=%0d",
                                 ALU_result, Zero, store_data, branch_target, out_rd, e.res, e.z, e.st, e.bt, e.rd);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({stall, out_valid, ALU_result, Zero, store_data, branch_target, out_rd} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got stall=%b v=%b res=%h z=%b st=%h bt=%h rd=%0d, want all 0",
                     stall, out_valid, ALU_result, Zero, store_data, branch_target, out_rd);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        set_op(2'b10, 6'h20, 32'd5, 32'd7, 0, 0, 5'd1, 0, 0, 0, 0, 0, 1); tick();
        n_cmp++;
        if ({out_valid, ALU_result, Zero} !== {1'b1, 32'd12, 1'b0}) begin
            n_err++;
            $display("FAIL alu_add: got v=%b res=%h z=%b, want v=1 res=0000000c z=0", out_valid, ALU_result, Zero);
        end
        set_op(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, 0, 0, 5'd2, 0, 0, 0, 0, 0, 1); tick();
        n_cmp++;
        if (ALU_result !== 32'd1) begin
            n_err++;
            $display("FAIL alu_slt: got %h, want 00000001", ALU_result);
        end
        set_op(2'b10, 6'h24, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 0, 5'd3, 0, 0, 0, 0, 0, 1); tick();
        set_op(2'b10, 6'h25, 32'hF000_0001, 32'h0000_0F00, 0, 0, 5'd4, 0, 0, 0, 0, 0, 1); tick();
        set_op(2'b10, 6'h27, 32'h0000_00FF, 32'hFF00_0000, 0, 0, 5'd5, 0, 0, 0, 0, 0, 1); tick();
        set_op(2'b10, 6'h3F, 32'h1111_1111, 32'h2222_2222, 0, 0, 5'd6, 0, 0, 0, 0, 0, 1); tick();
        set_op(2'b11, 6'h22, 32'hFFFF_FFFF, 32'd0, 32'd2, 0, 5'd7, 1, 0, 0, 0, 0, 1); tick();
        set_op(2'b00, 6'h00, 32'h7FFF_FFFF, 32'd1, 0, 0, 5'd8, 0, 0, 0, 0, 0, 1); tick();
        in_valid = 1'b0; tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_valid: got %b, want 0", out_valid);
        end
    endtask

    task automatic test_branch();
        set_op(2'b01, 6'h00, 32'h1234, 32'h1234, 32'd4, 32'h100, 5'd0, 0, 0, 0, 0, 0, 1); tick();
        n_cmp++;
        if ({Zero, branch_target} !== {1'b1, 32'h110}) begin
            n_err++;
            $display("FAIL branch: got z=%b bt=%h, want z=1 bt=00000110", Zero, branch_target);
        end
        set_op(2'b01, 6'h00, 32'd1, 32'd2, 32'hFFFF_FFFF, 32'h8, 5'd9, 0, 0, 0, 0, 0, 1); tick();
        in_valid = 1'b0;
    endtask

    task automatic test_forward();
        set_op(2'b10, 6'h22, 32'hDEAD, 32'hBEEF, 0, 0, 5'd10, 0, 2'b01, 2'b10, 32'd9, 32'd3, 1); tick();
        n_cmp++;
        if (ALU_result !== 32'd6) begin
            n_err++;
            $display("FAIL fwd_sub: got %h, want 00000006", ALU_result);
        end
        set_op(2'b10, 6'h22, 32'hDEAD, 32'hBEEF, 32'd1, 0, 5'd11, 1, 2'b01, 2'b10, 32'd9, 32'd3, 1); tick();
        n_cmp++;
        if ({ALU_result, store_data} !== {32'd8, 32'd3}) begin
            n_err++;
            $display("FAIL fwd_imm: got res=%h st=%h, want res=00000008 st=00000003", ALU_result, store_data);
        end
        set_op(2'b00, 6'h00, 32'd100, 32'd200, 0, 0, 5'd12, 0, 2'b11, 2'b11, 32'd9, 32'd3, 1); tick();
        in_valid = 1'b0;
    endtask

    task automatic test_mul();
        set_op(2'b10, 6'h18, 32'd7, 32'd6, 0, 32'h40, 5'd13, 0, 0, 0, 0, 0, 1); tick();
        set_op(2'b10, 6'h20, 32'd20, 32'd22, 0, 0, 5'd14, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if ({stall, out_valid} !== 2'b10) begin
                n_err++;
                $display("FAIL mul_stall[%0d]: got stall=%b v=%b, want stall=1 v=0", i, stall, out_valid);
            end
            tick();
        end
        n_cmp++;
        if ({stall, out_valid, ALU_result} !== {1'b0, 1'b1, 32'd42}) begin
            n_err++;
            $display("FAIL mul_done: got stall=%b v=%b res=%h, want stall=0 v=1 res=0000002a", stall, out_valid, ALU_result);
        end
        tick();
        n_cmp++;
        if ({out_valid, ALU_result} !== {1'b1, 32'd42}) begin
            n_err++;
            $display("FAIL mul_next_add: got v=%b res=%h, want v=1 res=0000002a", out_valid, ALU_result);
        end
        in_valid = 1'b0;
        tick();
        set_op(2'b10, 6'h18, 32'hFFFF_FFFF, 32'h1234_5679, 0, 0, 5'd15, 0, 0, 0, 0, 0, 1); tick();
        in_valid = 1'b0;
        repeat (34) tick();
    endtask

    task automatic test_flush_rst();
        set_op(2'b10, 6'h18, 32'd7, 32'd6, 0, 0, 5'd16, 0, 0, 0, 0, 0, 0); tick();
        in_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1; tick(); flush = 1'b0;
        n_cmp++;
        if ({stall, out_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL flush: got stall=%b v=%b, want 0 0", stall, out_valid);
        end
        repeat (40) tick();
        set_op(2'b10, 6'h18, 32'd9, 32'd9, 0, 0, 5'd17, 0, 0, 0, 0, 0, 0); tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++;
        if ({stall, out_valid, ALU_result, Zero, store_data, branch_target, out_rd} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_mul: got stall=%b v=%b res=%h z=%b st=%h bt=%h rd=%0d, want all 0",
                     stall, out_valid, ALU_result, Zero, store_data, branch_target, out_rd);
        end
        repeat (40) tick();
    endtask

    task automatic test_back_to_back();
        logic [5:0] fns [6];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        for (int i = 0; i < 10; i++) begin
            set_op(2'b10, fns[$urandom_range(0, 5)], $urandom, $urandom, $urandom, $urandom,
                   5'(i + 20), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), $urandom, $urandom, 1);
            tick();
            n_cmp++;
            if (out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_valid[%0d]: got %b, want 1", i, out_valid);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_mul_disabled();
        set_op(2'b10, 6'h18, 32'd7, 32'd6, 0, 0, 5'd30, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b0; in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        n_cmp++;
        if ({stall0, out_valid0, ALU_result0, Zero0, out_rd0} !== {1'b0, 1'b1, 32'd0, 1'b1, 5'd30}) begin
            n_err++;
            $display("FAIL nomul: got stall=%b v=%b res=%h z=%b rd=%0d, want stall=0 v=1 res=0 z=1 rd=30",
                     stall0, out_valid0, ALU_result0, Zero0, out_rd0);
        end
        tick();
        n_cmp++;
        if ({stall0, out_valid0} !== 2'b00) begin
            n_err++;
            $display("FAIL nomul_after: got stall=%b v=%b, want 0 0", stall0, out_valid0);
        end
    endtask

    initial begin
        fork
            monitor();
            begin
                #500000;
                $display("FAIL timeout: run exceeded time limit");
                $fatal(1, "timeout");
            end
        join_none
        test_reset();
        test_alu();
        test_branch();
        test_forward();
        test_mul();
        test_flush_rst();
        test_back_to_back();
        test_mul_disabled();
        repeat (3) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d results still pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

Parametrised, registered execute stage for the 5-stage core, sitting between the ID/EX and EX/MEM pipeline registers. It adds operand forwarding, branch-target computation, an iterative multi-cycle multiplier with pipeline stall, flush, and a registered EX/MEM output bundle. ALU_control decode semantics are kept, generalised to `XLEN`.

## Interface
- `XLEN`, 32: datapath width; ≥ 8.
- `MUL_EN`, 1: 1 enables the `mul` funct; 0 makes it an ordinary single-cycle op returning 0.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  ID/EX bundle valid.
- `function_code`  in  6  R-type funct field.
- `ALUOp`  in  2  00 add, 01 sub, 10 R-type by funct, 11 treated as add.
- `ALUSrc`  in  1  1 selects `imm` as operand B.
- `data1`, `data2`  in  XLEN  register-file operands.
- `imm`  in  XLEN  sign-extended immediate.
- `pc_plus4`  in  XLEN  PC+4 of the instruction.
- `rd`  in  5  destination register.
- `fwd_a_sel`, `fwd_b_sel`  in  2  00 register, 01 `mem_fwd_data`, 10 `wb_fwd_data`, 11 register.
- `mem_fwd_data`, `wb_fwd_data`  in  XLEN  forwarding sources.
- `flush`  in  1  kill the current and in-flight instruction.
- `stall`  out  1  upstream must hold the ID/EX bundle.
- `out_valid`  out  1  EX/MEM bundle valid.
- `ALU_result`  out  XLEN  result.
- `Zero`  out  1  `ALU_result == 0`.
- `store_data`  out  XLEN  forwarded operand B, taken before the ALUSrc mux.
- `branch_target`  out  XLEN  `pc_plus4 + (imm << 2)`, modulo 2^XLEN.
- `out_rd`  out  5  destination register.

## Operation
- Operand A is the forwarded `data1`.
- Operand B is the forwarded `data2`, replaced by `imm` when `ALUSrc = 1`.
- Funct decode, used only when `ALUOp = 10`:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor.
  - 0x2A slt: signed compare, result 1 or 0.
  - 0x18 mul: low XLEN bits of the unsigned product, multi-cycle.
  - Any other funct gives result 0.
- Arithmetic wraps modulo 2^XLEN. Overflow is ignored.
- FSM has two states, IDLE and MUL.
  - IDLE, accepting a single-cycle op (`in_valid & ~stall`, not mul): load all outputs, `out_valid = 1`.
  - IDLE, accepting mul with `MUL_EN = 1`: latch the operands, `rd` and `store_data`; count = 0; `out_valid = 0`; go to MUL.
  - IDLE, `in_valid = 0`: `out_valid = 0`; the other outputs hold.
  - MUL: one shift-add iteration per cycle, count++.
  - MUL, iteration at count = XLEN-1: load the product into `ALU_result`, set `out_valid = 1`, return to IDLE.
- `stall = (state == MUL)`, driven combinationally. Inputs are ignored while stalled.
- `flush` has priority over every other input except `rst`. Next cycle: `out_valid = 0`, state IDLE, count = 0, and the current input is not accepted.
- Reset puts the FSM in IDLE with count = 0. Every output register is 0, including `Zero`, so `stall = 0`.

## Timing
- Single-cycle ops: accepted at edge E, outputs valid after E. Latency 1, throughput 1 per cycle.
- mul, accepted at E0:
  - `stall` is high for exactly XLEN cycles, from E0 to E_XLEN.
  - `out_valid` is 0 for those cycles.
  - `out_valid` is 1 after E_XLEN, and a new instruction may be accepted at E_XLEN+1.
- Forwarding muxes are combinational from the inputs sampled at the accept edge. Forwarding values arriving during MUL are irrelevant.
- `Zero` is registered together with `ALU_result`, never derived from a stale value.
- `rst` or `flush` mid-MUL aborts the multiply; no partial result is ever presented.
- `out_valid` is a one-cycle pulse per accepted instruction; the other outputs may hold afterwards.

## Structure
- Package `ex_pkg` holds:
  - funct constants `FUNCT_ADD/SUB/AND/OR/NOR/SLT/MUL`;
  - ALUOp encodings;
  - forwarding-select encodings;
  - internal 4-bit operation enum;
  - FSM state enum.
- One sub-module, `ex_mul_iter`: iterative shift-add multiplier with `start`, `abort` and `done` ports, parametrised by `XLEN`. It is instantiated only when `MUL_EN = 1`.
- ALU, decode and forwarding muxes stay inline.

## Test plan
- Basic ALU, XLEN=32: `ALUOp=10`, funct 0x20, data1=5, data2=7 → next cycle `ALU_result=12`, `Zero=0`, `out_valid=1`. Funct 0x2A with data1=0xFFFFFFFF, data2=1 → result 1.
- Branch: `ALUOp=01`, data1=data2=0x1234, `imm=4`, `pc_plus4=0x100` → `Zero=1`, `branch_target=0x110`.
- Forwarding: `fwd_a_sel=01`, `mem_fwd_data=9`; `fwd_b_sel=10`, `wb_fwd_data=3`; funct 0x22 → result 6. With `ALUSrc=1`, `imm=1` → result 8, `store_data=3`.
- Multiply: funct 0x18 with 7×6 → `stall` high exactly 32 cycles, then result 42, `out_valid=1`. A new add presented throughout is accepted only on the cycle after `stall` falls.
- Flush and reset: `flush` raised at stall cycle 10 → `out_valid=0`, `stall=0` next cycle, no result pulse. `rst` mid-MUL → all outputs 0, IDLE.
- Back-to-back: ten single-cycle ops on consecutive cycles → ten `out_valid` pulses with results in order. `MUL_EN=0` with mul → result 0, no stall.
